// File: rtl/line_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_refill_pkg
// Purpose : Shared types and helpers for the line refill writer and the
//           RAM instance it feeds.
//           - lrw_state_t   : refill FSM state encoding
//           - lrw_line_addr : RAM word address from line index and offset
//           - LRW_*         : default geometry shared with the RAM instance
// Revision: 1.0 - initial release
// ============================================================================
package line_refill_pkg;

   localparam int LRW_DATA_WIDTH = 32;
   localparam int LRW_RAM_SIZE   = 1024;
   localparam int LRW_LINE_WORDS = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } lrw_state_t;

   // Word address = {idx, offset}. Callers truncate the result to their
   // address width; the offset never exceeds off_w bits, so the OR is a
   // plain concatenation.
   function automatic logic [31:0] lrw_line_addr(input logic [31:0] idx,
                                                 input logic [31:0] off,
                                                 input int          off_w);
      return (idx << off_w) | off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/line_refill_writer.sv
`default_nettype none
// ============================================================================
// Module  : line_refill_writer
// Purpose : Accepts one line-refill request, then LINE_WORDS data beats, and
//           drives the RAM write port one word per accepted beat. done_o
//           pulses only after the last word has been committed, so the wide
//           read side never observes a half-filled line.
// Ports   : clk, rst (async, active-high)
//           req_valid_i / req_ready_o / req_idx_i / req_off_i : request
//           beat_valid_i / beat_ready_o / beat_data_i / beat_last_i : data
//           ram_addr_o / ram_we_o / ram_wdata_o : RAM write port
//           done_o : line complete pulse, err_o : beat_last violation pulse
// Options : LINE_REFILL_CRITICAL_WORD_FIRST_EN - start the fill at req_off_i
//           and wrap within the line (otherwise always start at offset 0;
//           req_off_i stays on the interface in both builds).
// Revision: 1.0 - initial release
// ============================================================================
module line_refill_writer
   import line_refill_pkg::*;
#(
   parameter int DATA_WIDTH = LRW_DATA_WIDTH,
   parameter int RAM_SIZE   = LRW_RAM_SIZE,
   parameter int LINE_WORDS = LRW_LINE_WORDS,
   parameter int IDX_W      = $clog2(RAM_SIZE / LINE_WORDS),
   parameter int OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [IDX_W-1:0]            req_idx_i,
   input  logic [OFF_W-1:0]            req_off_i,
   input  logic                        beat_valid_i,
   output logic                        beat_ready_o,
   input  logic [DATA_WIDTH-1:0]       beat_data_i,
   input  logic                        beat_last_i,
   output logic [$clog2(RAM_SIZE)-1:0] ram_addr_o,
   output logic                        ram_we_o,
   output logic [DATA_WIDTH-1:0]       ram_wdata_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int ADDR_W = $clog2(RAM_SIZE);

   lrw_state_t             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [OFF_W-1:0]       r_off;
   logic [OFF_W-1:0]       r_cnt;
   logic                   r_req_ready;
   logic                   r_beat_ready;
   logic                   r_we;
   logic [ADDR_W-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic                   r_done;
   logic                   r_err;

   logic                   w_req_acc;
   logic                   w_beat_acc;
   logic                   w_cnt_full;
   logic                   w_final;
   logic [OFF_W-1:0]       w_start_off;
   logic [ADDR_W-1:0]      w_wr_addr;

`ifdef LINE_REFILL_CRITICAL_WORD_FIRST_EN
   assign w_start_off = req_off_i;
`else
   // Offset port is kept for interface compatibility but has no effect.
   logic w_unused_off;
   assign w_unused_off = ^req_off_i;
   assign w_start_off  = '0;
`endif

   // r_req_ready / r_beat_ready are only ever set in IDLE / FILL, so the
   // handshakes need no additional state qualification.
   assign w_req_acc  = req_valid_i & r_req_ready;
   assign w_beat_acc = beat_valid_i & r_beat_ready;
   assign w_cnt_full = (r_cnt == OFF_W'(LINE_WORDS - 1));
   assign w_final    = beat_last_i | w_cnt_full;
   assign w_wr_addr  = ADDR_W'(lrw_line_addr(32'(r_idx), 32'(r_off), OFF_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_off        <= '0;
         r_cnt        <= '0;
         r_req_ready  <= 1'b0;
         r_beat_ready <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_we        <= 1'b0;
               r_done      <= 1'b0;
               r_err       <= 1'b0;
               // Comes up not-ready straight out of reset, ready one cycle
               // later; a request can only be taken once ready is visible.
               r_req_ready <= 1'b1;
               if (w_req_acc) begin
                  r_req_ready  <= 1'b0;
                  r_beat_ready <= 1'b1;
                  r_idx        <= req_idx_i;
                  r_off        <= w_start_off;
                  r_cnt        <= '0;
                  r_state      <= S_FILL;
               end
            end

            S_FILL: begin
               r_we <= w_beat_acc;
               if (w_beat_acc) begin
                  r_addr  <= w_wr_addr;
                  r_wdata <= beat_data_i;
                  // Natural wrap of the OFF_W-bit offset keeps the fill
                  // inside the current line.
                  r_off   <= r_off + 1'b1;
                  r_cnt   <= r_cnt + 1'b1;
                  if (w_final) begin
                     r_beat_ready <= 1'b0;
                     // Exactly one of "last flagged" / "line full" is a
                     // protocol violation: early last or missing last.
                     r_err        <= beat_last_i ^ w_cnt_full;
                     r_state      <= S_FLUSH;
                  end
               end
            end

            S_FLUSH: begin
               // Final write is on the port this cycle.
               r_we    <= 1'b0;
               r_err   <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end

            S_DONE: begin
               r_done      <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: begin
               r_req_ready  <= 1'b0;
               r_beat_ready <= 1'b0;
               r_we         <= 1'b0;
               r_done       <= 1'b0;
               r_err        <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = r_req_ready;
   assign beat_ready_o = r_beat_ready;
   assign ram_addr_o   = r_addr;
   assign ram_we_o     = r_we;
   assign ram_wdata_o  = r_wdata;
   assign done_o       = r_done;
   assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_line_refill_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_line_refill_writer
// Purpose : Self-checking bench for line_refill_writer. Expected writes,
//           completion/error pulses and their cycles come from a line-level
//           model: a fill of n beats starting at offset s on line idx must
//           write idx*LINE_WORDS + (s+k) mod LINE_WORDS, one cycle after
//           each accept, with done two cycles after the final accept.
// Revision: 1.0 - initial release
// ============================================================================
module tb_line_refill_writer;

   localparam int DW     = 32;
   localparam int RS     = 1024;
   localparam int LW     = 8;
   localparam int IDX_W  = $clog2(RS / LW);
   localparam int OFF_W  = $clog2(LW);
   localparam int ADDR_W = $clog2(RS);

   logic                 clk;
   logic                 rst;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [IDX_W-1:0]     req_idx_i;
   logic [OFF_W-1:0]     req_off_i;
   logic                 beat_valid_i;
   logic                 beat_ready_o;
   logic [DW-1:0]        beat_data_i;
   logic                 beat_last_i;
   logic [ADDR_W-1:0]    ram_addr_o;
   logic                 ram_we_o;
   logic [DW-1:0]        ram_wdata_o;
   logic                 done_o;
   logic                 err_o;

   line_refill_writer #(
      .DATA_WIDTH (DW),
      .RAM_SIZE   (RS),
      .LINE_WORDS (LW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_idx_i    (req_idx_i),
      .req_off_i    (req_off_i),
      .beat_valid_i (beat_valid_i),
      .beat_ready_o (beat_ready_o),
      .beat_data_i  (beat_data_i),
      .beat_last_i  (beat_last_i),
      .ram_addr_o   (ram_addr_o),
      .ram_we_o     (ram_we_o),
      .ram_wdata_o  (ram_wdata_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          c;
   } wr_t;

   wr_t wq[$];
   int  done_n = 0;
   int  done_c = -1;
   int  err_n  = 0;
   int  err_c  = -1;

   // Observe the write port and pulses away from the active edge.
   always @(negedge clk) begin
      if (ram_we_o === 1'b1) wq.push_back('{int'(ram_addr_o), ram_wdata_o, cyc});
      if (done_o === 1'b1) begin
         done_n = done_n + 1;
         done_c = cyc;
      end
      if (err_o === 1'b1) begin
         err_n = err_n + 1;
         err_c = cyc;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      wq.delete();
      done_n = 0;
      done_c = -1;
      err_n  = 0;
      err_c  = -1;
   endtask

   task automatic wait_req_ready();
      for (int i = 0; i < 30; i++) begin
         if (req_ready_o === 1'b1) break;
         @(posedge clk); #1;
      end
      chk("req_ready_wait", 64'(req_ready_o), 64'd1);
   endtask

   // bmode: 0 = no bubbles, 1 = valid low every other cycle, 2 = random.
   task automatic run_fill(input int idx, input int off, input int nbeats,
                           input bit last_final, input int bmode, input bit fixed_data);
      int          exp_addr[$];
      logic [31:0] exp_data[$];
      int          acc_c[$];
      int          start;
      int          r_c;
      int          k;
      int          tick;
      int          t_last;
      bit          v;
      bit          err_exp;
      logic [31:0] d;

`ifdef LINE_REFILL_CRITICAL_WORD_FIRST_EN
      start = off;
`else
      start = 0;
`endif
      err_exp = (nbeats < LW) ? 1'b1 : !last_final;

      wait_req_ready();
      clear_mon();
      req_valid_i = 1'b1;
      req_idx_i   = IDX_W'(idx);
      req_off_i   = OFF_W'(off);
      r_c = cyc;
      @(posedge clk); #1;
      req_valid_i = 1'b0;

      k = 0;
      tick = 0;
      while (k < nbeats) begin
         if (tick > 500) begin
            chk("beat_loop_timeout", 64'(k), 64'(nbeats));
            break;
         end
         case (bmode)
            0:       v = 1'b1;
            1:       v = (tick % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         chk("beat_ready_fill", 64'(beat_ready_o), 64'd1);
         d = fixed_data ? (32'hA0 + 32'(k)) : $urandom;
         beat_valid_i = v;
         beat_data_i  = d;
         beat_last_i  = v && (k == nbeats - 1) && ((nbeats < LW) || last_final);
         if (v) begin
            exp_addr.push_back(idx * LW + ((start + k) % LW));
            exp_data.push_back(d);
            acc_c.push_back(cyc);
            k++;
         end
         @(posedge clk); #1;
         beat_valid_i = 1'b0;
         beat_last_i  = 1'b0;
         tick++;
      end

      t_last = (acc_c.size() > 0) ? acc_c[$] : cyc;
      if (bmode == 0 && acc_c.size() > 0)
         chk("first_beat_latency", 64'(acc_c[0]), 64'(r_c + 1));
      chk("beat_ready_flush", 64'(beat_ready_o), 64'd0);
      chk("req_ready_flush", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("req_ready_after_done", 64'(req_ready_o), 64'd1);
      @(posedge clk); #1;

      chk("n_writes", 64'(wq.size()), 64'(nbeats));
      for (int i = 0; i < nbeats && i < wq.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), 64'(wq[i].addr), 64'(exp_addr[i]));
         chk($sformatf("wr_data[%0d]", i), 64'(wq[i].data), 64'(exp_data[i]));
         chk($sformatf("wr_cycle[%0d]", i), 64'(wq[i].c), 64'(acc_c[i] + 1));
      end
      chk("done_count", 64'(done_n), 64'd1);
      chk("done_cycle", 64'(done_c), 64'(t_last + 2));
      chk("err_count", 64'(err_n), 64'(err_exp));
      if (err_exp) chk("err_cycle", 64'(err_c), 64'(t_last + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst          = 1'b1;
      req_valid_i  = 1'b0;
      req_idx_i    = '0;
      req_off_i    = '0;
      beat_valid_i = 1'b0;
      beat_data_i  = '0;
      beat_last_i  = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_beat_ready", 64'(beat_ready_o), 64'd0);
      chk("rst_we", 64'(ram_we_o), 64'd0);
      chk("rst_addr", 64'(ram_addr_o), 64'd0);
      chk("rst_wdata", 64'(ram_wdata_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Nominal fill: idx 3, data A0..A7, last on the 8th beat
      run_fill(3, 0, LW, 1'b1, 0, 1'b1);
      // Same fill with valid low every other cycle
      run_fill(3, 0, LW, 1'b1, 1, 1'b1);
      // Top line, offset 6: wraps inside line 127 only
      run_fill(127, 6, LW, 1'b1, 0, 1'b0);
      // Early last on the 5th beat
      run_fill(9, 0, 5, 1'b1, 0, 1'b0);
      // Full line without last marker
      run_fill(17, 2, LW, 1'b0, 0, 1'b0);

      // Reset during a fill after three beats
      wait_req_ready();
      clear_mon();
      req_valid_i = 1'b1;
      req_idx_i   = IDX_W'(5);
      req_off_i   = '0;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat_valid_i = 1'b1;
         beat_data_i  = $urandom;
         @(posedge clk); #1;
      end
      beat_valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_req_ready", 64'(req_ready_o), 64'd0);
      chk("midrst_beat_ready", 64'(beat_ready_o), 64'd0);
      chk("midrst_we", 64'(ram_we_o), 64'd0);
      chk("midrst_addr", 64'(ram_addr_o), 64'd0);
      chk("midrst_wdata", 64'(ram_wdata_o), 64'd0);
      clear_mon();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_no_done", 64'(done_n), 64'd0);
      chk("midrst_no_err", 64'(err_n), 64'd0);
      chk("midrst_no_write", 64'(wq.size()), 64'd0);
      run_fill(0, 0, LW, 1'b1, 0, 1'b0);

      // Randomised fills
      for (int t = 0; t < 8; t++) begin
         n = ($urandom_range(0, 1) == 1) ? LW : int'($urandom_range(1, LW));
         run_fill(int'($urandom_range(0, RS / LW - 1)), int'($urandom_range(0, LW - 1)),
                  n, 1'($urandom_range(0, 1)), 2, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
